// File: rtl/procesor_driver_if.sv
// Procesor-side bus: the driver is master, the procesor (or its model) is slave.
interface procesor_driver_if #(parameter int DATA_W = 32);
  logic              proc_reset;
  logic [DATA_W-1:0] proc_data;
  logic              proc_data_ready;
  logic [3:0]        proc_opcode;
  logic [DATA_W-1:0] proc_constant;
  logic [DATA_W-1:0] proc_out;
  logic              proc_out_valid;

  modport master (output proc_reset, proc_data, proc_data_ready, proc_opcode, proc_constant,
                  input  proc_out, proc_out_valid);
  modport slave  (input  proc_reset, proc_data, proc_data_ready, proc_opcode, proc_constant,
                  output proc_out, proc_out_valid);
endinterface

// File: rtl/procesor_driver.sv
// Host-side job issuer for the procesor: streams preloaded operands, waits for
// out_valid and captures the 8-word result burst into a readable buffer.
module procesor_driver #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [3:0]            load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [DATA_W-1:0]     constant,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [2:0]            rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  procesor_driver_if.master     proc
);
  localparam logic [2:0] IDLE = 3'd0, RST = 3'd1, SEND = 3'd2,
                         WAIT = 3'd3, CAPT = 3'd4, DONE = 3'd5;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]        state;
  logic [4:0]        n_q, cnt;
  logic [2:0]        idx;
  logic [TW-1:0]     tmo;
  logic              err_q;
  logic [DATA_W-1:0] opnd [16];
  logic [DATA_W-1:0] res  [8];

  function automatic logic [4:0] n_words(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'hD, 4'hF:       n_words = 5'd16;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE: n_words = 5'd8;
      default:                            n_words = 5'd0;
    endcase
  endfunction

  assign busy    = (state == RST) || (state == SEND) || (state == WAIT) || (state == CAPT);
  assign done    = (state == DONE);
  assign err     = err_q;
  assign rd_data = res[rd_addr];

  // Operand buffer survives reset so the host can preload before releasing it.
  always_ff @(posedge clk)
    if (load_en) opnd[load_addr] <= load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      n_q                  <= '0;
      cnt                  <= '0;
      idx                  <= '0;
      tmo                  <= '0;
      err_q                <= 1'b0;
      proc.proc_reset      <= 1'b0;
      proc.proc_data       <= '0;
      proc.proc_data_ready <= 1'b0;
      proc.proc_opcode     <= '0;
      proc.proc_constant   <= '0;
      for (int i = 0; i < 8; i++) res[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          proc.proc_opcode   <= opcode;
          proc.proc_constant <= constant;
          n_q                <= n_words(opcode);
          if (opcode[3:2] == 2'b01) begin
            state <= DONE;
            err_q <= 1'b1;
          end else begin
            state           <= RST;
            err_q           <= 1'b0;
            proc.proc_reset <= 1'b1;
          end
        end
        RST: begin
          proc.proc_reset <= 1'b0;
          if (n_q == 5'd0) state <= DONE;
          else begin
            state                <= SEND;
            proc.proc_data       <= opnd[0];
            proc.proc_data_ready <= 1'b1;
            cnt                  <= 5'd1;
          end
        end
        // cnt is the index of the next word to present; word N-1 gets its full cycle.
        SEND: begin
          if (cnt == n_q) begin
            state <= WAIT;
            tmo   <= '0;
          end else begin
            proc.proc_data <= opnd[cnt[3:0]];
            cnt            <= cnt + 5'd1;
          end
        end
        WAIT: begin
          if (proc.proc_out_valid) begin
            res[0] <= proc.proc_out;
            idx    <= 3'd1;
            state  <= CAPT;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            state                <= DONE;
            err_q                <= 1'b1;
            proc.proc_data_ready <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CAPT: begin
          res[idx] <= proc.proc_out;
          if (idx == 3'd7) begin
            state                <= DONE;
            proc.proc_data_ready <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_procesor_driver.sv
// Scoreboard bench: expected operand words and procesor-model results are
// queued as stimulus is driven and popped when the driver presents them.
module tb_procesor_driver;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [3:0]        load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] constant;
  logic              busy, done, err;
  logic [2:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;

  procesor_driver_if #(.DATA_W(DATA_W)) pif();

  procesor_driver #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .opcode(opcode), .constant(constant),
    .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data),
    .proc(pif.master)
  );

  always #5 clk = ~clk;

  int                n_chk  = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] opnd_m [16];
  logic [DATA_W-1:0] last_res [8];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] res_q [$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    for (int j = 0; j < 8; j++) begin
      rd_addr = 3'(j);
      #1 chk(tag, rd_data, last_res[j]);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = 4'(i);
      load_data = (i == 0) ? 32'hD5AE417B : (i == 8) ? 32'h6FC403C3 : $urandom;
      opnd_m[i] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // respond=0: the procesor model never raises out_valid.
  task automatic run_job(input logic [3:0] op, input logic [DATA_W-1:0] k, input int n,
                         input bit respond, input int lat, input logic [DATA_W-1:0] rbase);
    logic [DATA_W-1:0] last;
    int k_cyc;
    @(negedge clk);
    start = 1'b1; opcode = op; constant = k;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pulse", 32'(pif.proc_reset), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rdy", 32'(pif.proc_data_ready), 0);
    chk("opcode", 32'(pif.proc_opcode), 32'(op));
    chk("const", pif.proc_constant, k);
    for (int i = 0; i < n; i++) exp_q.push_back(opnd_m[i]);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      last = exp_q.pop_front();
      chk("send_rdy", 32'(pif.proc_data_ready), 1);
      chk("send_rst", 32'(pif.proc_reset), 0);
      chk("word", pif.proc_data, last);
      // start while busy must be ignored
      if (i == 2) begin start = 1'b1; opcode = 4'h5; end
      if (i == 3) begin start = 1'b0; opcode = op; end
    end
    if (!respond) begin
      k_cyc = 0;
      while (!done && k_cyc < TIMEOUT + 10) begin
        @(negedge clk);
        k_cyc++;
      end
      chk("tmo_cycles", 32'(k_cyc), 32'(TIMEOUT + 1));
      chk("tmo_err", 32'(err), 1);
      chk("tmo_rdy", 32'(pif.proc_data_ready), 0);
      return;
    end
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      chk("wait_rdy", 32'(pif.proc_data_ready), 1);
      chk("wait_hold", pif.proc_data, last);
      chk("wait_done", 32'(done), 0);
    end
    pif.proc_out_valid = 1'b1; pif.proc_out = rbase;
    res_q.push_back(rbase);
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      chk("capt_rdy", 32'(pif.proc_data_ready), 1);
      pif.proc_out_valid = 1'b0; pif.proc_out = rbase + 32'(j);
      res_q.push_back(rbase + 32'(j));
    end
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_rdy", 32'(pif.proc_data_ready), 0);
    chk("done_const", pif.proc_constant, k);
    for (int j = 0; j < 8; j++) begin
      last_res[j] = res_q.pop_front();
      rd_addr = 3'(j);
      #1 chk("result", rd_data, last_res[j]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; opcode = '0; constant = '0; rd_addr = '0;
    pif.proc_out = '0; pif.proc_out_valid = 1'b0;
    for (int j = 0; j < 8; j++) last_res[j] = '0;
    #12;
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_done0", 32'(done), 0);
    chk("rst_err0", 32'(err), 0);
    chk("rst_preset0", 32'(pif.proc_reset), 0);
    chk("rst_rdy0", 32'(pif.proc_data_ready), 0);
    chk("rst_data0", pif.proc_data, 0);
    chk_results("rst_res0");
    @(negedge clk);
    reset = 1'b0;
    load_ops();

    run_job(4'h2, 32'h0, 16, 1'b1, 3, 32'h1);             // ADD
    run_job(4'h8, 32'h1234, 8, 1'b1, 2, 32'h100);         // SDC
    run_job(4'hC, 32'hD5AE417B, 8, 1'b1, 1, 32'hA0);      // AWC

    // NOP: reset pulse, no words, done two cycles after start
    @(negedge clk);
    start = 1'b1; opcode = 4'h0; constant = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("nop_rst", 32'(pif.proc_reset), 1);
    @(negedge clk);
    chk("nop_done", 32'(done), 1);
    chk("nop_err", 32'(err), 0);
    chk("nop_rdy", 32'(pif.proc_data_ready), 0);
    chk_results("nop_res");

    run_job(4'h1, 32'h0, 16, 1'b0, 0, 32'h0);             // MUL, timeout

    // illegal opcode: straight to DONE with err, no procesor reset
    @(negedge clk);
    start = 1'b1; opcode = 4'h5;
    @(posedge clk);
    #1 chk("ill_preset", 32'(pif.proc_reset), 0);
    @(negedge clk);
    start = 1'b0;
    chk("ill_done", 32'(done), 1);
    chk("ill_err", 32'(err), 1);
    chk("ill_preset2", 32'(pif.proc_reset), 0);

    // async reset mid-SEND
    @(negedge clk);
    start = 1'b1; opcode = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdy", 32'(pif.proc_data_ready), 0);
    chk("abort_data", pif.proc_data, 0);
    for (int j = 0; j < 8; j++) last_res[j] = '0;
    chk_results("abort_res");
    @(negedge clk);
    reset = 1'b0;

    run_job(4'hF, 32'h55AA, 16, 1'b1, 2, 32'h500);        // XOR after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
